// File: rtl/hack_pkg.sv
// Shared definitions for the Hack machine blocks: word/address widths and the
// state encoding of the RAM word loader.
package hack_pkg;

    localparam int WORD_WIDTH        = 16;
    localparam int RAM_ADDRESS_WIDTH = 15;

    typedef enum logic [2:0] {
        LD_IDLE     = 3'd0,
        LD_COUNT_HI = 3'd1,
        LD_COUNT_LO = 3'd2,
        LD_DATA_HI  = 3'd3,
        LD_DATA_LO  = 3'd4,
        LD_WRITE    = 3'd5,
        LD_DONE     = 3'd6,
        LD_ERROR    = 3'd7
    } loader_state_e;

endpackage

// File: rtl/byte_pair_assembler.sv
// Builds a big-endian 16-bit word from a high byte and a following low byte and
// flags the completed word for exactly one cycle.
module byte_pair_assembler
    import hack_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [7:0]            byte_i,
    input  logic                  capture_hi_i,
    input  logic                  capture_lo_i,
    output logic [WORD_WIDTH-1:0] word_o,
    output logic                  word_valid_o
);

    logic [7:0]            hi_q;
    logic [WORD_WIDTH-1:0] word_q;
    logic                  valid_q;

    // word_q only changes on a completed pair, so it holds between writes
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hi_q    <= 8'h00;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= capture_lo_i;
            if (capture_hi_i) begin
                hi_q <= byte_i;
            end
            if (capture_lo_i) begin
                word_q <= {hi_q, byte_i};
            end
        end
    end

    assign word_o       = word_q;
    assign word_valid_o = valid_q;

endmodule

// File: rtl/ram_word_loader.sv
// Loads a counted stream of big-endian words into consecutive RAM addresses,
// starting at BASE_ADDRESS; the header is a 16-bit word count.
module ram_word_loader
    import hack_pkg::*;
#(
    parameter int ADDRESS_WIDTH = RAM_ADDRESS_WIDTH,
    parameter int BASE_ADDRESS  = 0
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [7:0]               in_byte,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WORD_WIDTH-1:0]    ram_in,
    output logic                     ram_load,
    output logic [ADDRESS_WIDTH-1:0] ram_address,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [15:0]              words_written
);

    localparam logic [ADDRESS_WIDTH-1:0] BASE_PTR = ADDRESS_WIDTH'(BASE_ADDRESS);
    // Words that fit between BASE_ADDRESS and the top of the RAM
    localparam logic [31:0] CAPACITY = 32'((64'd1 << ADDRESS_WIDTH) - 64'(BASE_ADDRESS));

    loader_state_e            state_q;
    logic                     in_ready_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     error_q;
    logic [15:0]              words_q;
    logic [15:0]              remaining_q;
    logic [7:0]               count_hi_q;
    logic [ADDRESS_WIDTH-1:0] ptr_q;
    logic [ADDRESS_WIDTH-1:0] ram_address_q;

    logic        accept;
    logic [15:0] hdr_count;

    assign accept    = in_valid && in_ready_q;
    assign hdr_count = {count_hi_q, in_byte};

    byte_pair_assembler u_assembler (
        .clk_i       (clock),
        .rst_ni      (reset_n),
        .byte_i      (in_byte),
        .capture_hi_i(accept && (state_q == LD_DATA_HI)),
        .capture_lo_i(accept && (state_q == LD_DATA_LO)),
        .word_o      (ram_in),
        .word_valid_o(ram_load)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= LD_IDLE;
            in_ready_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            words_q       <= 16'd0;
            remaining_q   <= 16'd0;
            count_hi_q    <= 8'h00;
            ptr_q         <= BASE_PTR;
            ram_address_q <= BASE_PTR;
        end else begin
            case (state_q)
                LD_IDLE, LD_DONE, LD_ERROR: begin
                    if (start) begin
                        state_q    <= LD_COUNT_HI;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                        words_q    <= 16'd0;
                        ptr_q      <= BASE_PTR;
                    end
                end
                LD_COUNT_HI: begin
                    if (accept) begin
                        count_hi_q <= in_byte;
                        state_q    <= LD_COUNT_LO;
                    end
                end
                LD_COUNT_LO: begin
                    if (accept) begin
                        if (hdr_count == 16'd0) begin
                            state_q    <= LD_DONE;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                        end else if ({16'd0, hdr_count} > CAPACITY) begin
                            state_q    <= LD_ERROR;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                            error_q    <= 1'b1;
                        end else begin
                            state_q     <= LD_DATA_HI;
                            remaining_q <= hdr_count;
                        end
                    end
                end
                LD_DATA_HI: begin
                    if (accept) begin
                        state_q <= LD_DATA_LO;
                    end
                end
                LD_DATA_LO: begin
                    if (accept) begin
                        state_q       <= LD_WRITE;
                        in_ready_q    <= 1'b0;
                        ram_address_q <= ptr_q;
                    end
                end
                LD_WRITE: begin
                    ptr_q       <= ptr_q + 1'b1;
                    words_q     <= words_q + 16'd1;
                    remaining_q <= remaining_q - 16'd1;
                    if (remaining_q == 16'd1) begin
                        state_q <= LD_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q    <= LD_DATA_HI;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= LD_IDLE;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready      = in_ready_q;
    assign ram_address   = ram_address_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign words_written = words_q;

endmodule
